// File: rtl/div16_seq_if.sv
// Start/done handshake and operand/result bundle between a controller and div16_seq.
interface div16_seq_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div16_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock via a single
// (WIDTH+1)-bit trial subtraction, with a start/done handshake.
module div16_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  div16_seq_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    count, count_d;
  logic [WIDTH-1:0] q_reg, q_d;
  logic [WIDTH-1:0] r_reg, r_d;
  logic [WIDTH-1:0] d_reg, d_d;
  logic             dbz_reg, dbz_d;
  logic             busy_reg, busy_d;
  logic             done_reg, done_d;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;

  // Stored remainder is always below the divisor, so WIDTH bits suffice;
  // only the shifted partial remainder needs the extra bit.
  always_comb begin
    state_d = state;
    count_d = count;
    q_d     = q_reg;
    r_d     = r_reg;
    d_d     = d_reg;
    dbz_d   = dbz_reg;
    r_shift = {r_reg, q_reg[WIDTH-1]};
    trial   = r_shift + {1'b1, ~d_reg} + (WIDTH+1)'(1);

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            q_d     = '1;
            r_d     = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = bus.dividend;
            r_d     = '0;
            d_d     = bus.divisor;
            dbz_d   = 1'b0;
            count_d = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Top bit of the trial sum clear means no borrow: keep the difference.
        if (!trial[WIDTH]) begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_reg[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_shift[WIDTH-1:0];
          q_d = {q_reg[WIDTH-2:0], 1'b0};
        end
        count_d = count + CW'(1);
        if (count == CW'(WIDTH-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      d_reg    <= '0;
      dbz_reg  <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      q_reg    <= q_d;
      r_reg    <= r_d;
      d_reg    <= d_d;
      dbz_reg  <= dbz_d;
      busy_reg <= busy_d;
      done_reg <= done_d;
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = q_reg;
  assign bus.remainder   = r_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule
